// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Booth pair codes for {Q[0], q_-1}; 00 and 11 are both no-ops.
    localparam logic [1:0] PAIR_NOP = 2'b00;
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    // Counter must hold E = width+1 iterations.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub M, then arithmetic shift of {A,Q,q_-1}.
module booth_step #(
    parameter int unsigned E = 9
) (
    input  logic [E:0]   a_i,
    input  logic [E-1:0] q_i,
    input  logic         qm1_i,
    input  logic [E-1:0] m_i,
    output logic [E:0]   a_o,
    output logic [E-1:0] q_o,
    output logic         qm1_o
);
    import booth_pkg::*;

    logic [E:0] m_ext;
    logic [E:0] a_sum;

    assign m_ext = {m_i[E-1], m_i};

    // Apply the Booth add/subtract selected by the current pair code.
    always_comb begin
        a_sum = a_i;
        case ({q_i[0], qm1_i})
            PAIR_ADD: a_sum = a_i + m_ext;
            PAIR_SUB: a_sum = a_i - m_ext;
            default:  a_sum = a_i;
        endcase
    end

    // Arithmetic right shift of the concatenated {A,Q,q_-1}, keeping A's sign.
    always_comb begin
        a_o   = {a_sum[E], a_sum[E:1]};
        q_o   = {a_sum[0], q_i[E-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier with valid/ready handshakes on both sides.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);
    localparam int unsigned E = WIDTH + 1;

    state_e             state_q, state_d;
    logic [E:0]         a_q, a_d;
    logic [E-1:0]       q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [E-1:0]       m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [E:0]         a_nxt;
    logic [E-1:0]       q_nxt;
    logic               qm1_nxt;
    logic               last_step;

    booth_step #(.E(E)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_nxt),
        .q_o   (q_nxt),
        .qm1_o (qm1_nxt)
    );

    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_step) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q == RUN) || (state_q == HOLD);
    end

    // Datapath next values: operand load on accept, one Booth step per RUN cycle.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        m_d   = m_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        if (in_valid && in_ready) begin
            m_d   = in_signed ? {in_a[WIDTH-1], in_a} : {1'b0, in_a};
            q_d   = in_signed ? {in_b[WIDTH-1], in_b} : {1'b0, in_b};
            a_d   = '0;
            qm1_d = 1'b0;
            cnt_d = CNT_W'(E);
        end else if (state_q == RUN) begin
            a_d   = a_nxt;
            q_d   = q_nxt;
            qm1_d = qm1_nxt;
            cnt_d = cnt_q - CNT_W'(1);
            // Product is captured from the final step's outputs so out_p is valid with out_valid.
            if (last_step) p_d = {a_nxt[WIDTH-2:0], q_nxt};
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    assign out_p = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq with directed, hand-computed vectors (WIDTH=8).
module tb_booth_mult_seq;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_signed = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_p;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;
    logic [2*W-1:0] exp_q[$];

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge when both are high at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                handshakes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL product: got %h expected none (unexpected result)", out_p);
                end else begin
                    logic [2*W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_p !== e) begin
                        errors++;
                        $display("FAIL product: got %h expected %h", out_p, e);
                    end
                end
            end
        end
    end

    // Issue one operand pair; returns 1 time unit after the acceptance edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] e);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
            @(posedge clk);
            exp_q.push_back(e);
            #1;
            in_valid = 1'b0;
            in_a = ~a; in_b = a ^ b; in_signed = ~s;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cyc;
        logic [2*W-1:0] held;
        int hs0;

        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h01, 8'h80, 1'b1, 16'hFF80});
        vecs.push_back('{8'h80, 8'h7F, 1'b0, 16'h3F80});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 16'h3872});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 16'hE372});
        vecs.push_back('{8'h00, 8'hC3, 1'b1, 16'h0000});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});

        // Reset values while held in reset.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed -3 x 5 with latency measurement.
        issue(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("latency", 32'(cyc), 32'd9);
        drain();

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
        drain();

        // Backpressure: result must stay put and inputs be ignored while downstream stalls.
        out_ready = 1'b0;
        issue(8'h13, 8'hF1, 1'b1, 16'hFEE3);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        held = out_p;
        hs0 = handshakes;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_a = 8'(i * 7);
            @(posedge clk); #1;
            if (out_p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                check("bp_stable", {out_p, 14'd0, in_ready, out_valid}, {held, 16'h0001});
            end
        end
        check("bp_stable_end", 32'(out_p), 32'(held));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_single_hs", 32'(handshakes - hs0), 32'd1);

        // Asynchronous reset mid-run discards the in-flight result.
        issue(8'h7F, 8'h7F, 1'b1, 16'h3F01);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_p", 32'(out_p), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        hs0 = handshakes;
        issue(8'h07, 8'h06, 1'b0, 16'h002A);
        drain();
        check("post_rst_hs", 32'(handshakes - hs0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
